// File: rtl/io_pkg.sv
// io_pkg: FSM state type and default parameters shared by the IO write arbiter and bridge
package io_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } io_state_e;
  localparam int IO_NUM_REQ    = 4;
  localparam int IO_DATA_WIDTH = 8;
  localparam int IO_MAX_BURST  = 4;
  localparam int IO_DRAIN_CYC  = 2;
endpackage

// File: rtl/io_wr_arbiter_if.sv
// io_wr_arbiter_if: requester and bridge write signals seen by the IO write arbiter
interface io_wr_arbiter_if
  import io_pkg::*;
#(
  parameter int NUM_REQ    = IO_NUM_REQ,
  parameter int DATA_WIDTH = IO_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            ack_o;
  logic                          io_req_w_o;
  logic [DATA_WIDTH-1:0]         io_data_o;
  logic                          io_ack_w_i;
  modport slave (
    input  req_i, data_i, io_ack_w_i,
    output gnt_o, ack_o, io_req_w_o, io_data_o
  );
  modport master (
    output req_i, data_i, io_ack_w_i,
    input  gnt_o, ack_o, io_req_w_o, io_data_o
  );
endinterface

// File: rtl/io_rr_picker.sv
// io_rr_picker: combinational round-robin pick, one-hot winner searching upward from last owner + 1
module io_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         win_o
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] k;
  logic          found;
  // first set request after last_i, wrapping around, wins
  always_comb begin
    win_o = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IW'((int'(last_i) + i) % NUM_REQ);
      if (!found && req_i[k]) begin
        win_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_wr_arbiter.sv
// io_wr_arbiter: round-robin write arbiter to the IO bridge; define IO_ARB_BURST_LIMIT_EN for forced release after MAX_BURST acks
module io_wr_arbiter
  import io_pkg::*;
#(
  parameter int NUM_REQ    = IO_NUM_REQ,
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int MAX_BURST  = IO_MAX_BURST,
  parameter int DRAIN_CYC  = IO_DRAIN_CYC
) (
  input logic            clk,
  input logic            reset,
  io_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || DRAIN_CYC < 1 || DRAIN_CYC > 7)
    $error("io_wr_arbiter: parameter out of range");
  io_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d, win;
  logic [IW-1:0]         last_q, last_d, owner;
  logic [2:0]            dcnt_q, dcnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, owner_data;
  logic                  own_req, grant_done, active;
  io_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i  (bus.req_i),
    .last_i (last_q),
    .win_o  (win)
  );
  // index of the one-hot grant
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) owner = IW'(i);
  end
  assign owner_data     = bus.data_i[owner*DATA_WIDTH +: DATA_WIDTH];
  assign own_req        = |(bus.req_i & gnt_q);
  assign active         = (state_q == GRANT) || (state_q == DRAIN);
  assign bus.gnt_o      = gnt_q;
  assign bus.ack_o      = (active && bus.io_ack_w_i) ? gnt_q : '0;
  assign bus.io_req_w_o = (state_q == GRANT) && own_req;
  assign bus.io_data_o  = (state_q == GRANT) ? owner_data : hold_q;
`ifdef IO_ARB_BURST_LIMIT_EN
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d      = (state_q == GRANT) ? cnt_q + {7'd0, bus.io_ack_w_i} : 8'd0;
  assign grant_done = !own_req || (cnt_d == 8'(MAX_BURST));
  // burst counter, zero outside GRANT so every grant starts from 0
  always_ff @(posedge clk)
    cnt_q <= reset ? 8'd0 : cnt_d;
`else
  assign grant_done = !own_req;
`endif
  // next state: pick in IDLE, hold owner through GRANT, timed DRAIN then release
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hold_d  = hold_q;
    dcnt_d  = '0;
    case (state_q)
      IDLE: begin
        gnt_d   = win;
        state_d = |bus.req_i ? GRANT : IDLE;
      end
      GRANT: begin
        hold_d  = owner_data;
        state_d = grant_done ? DRAIN : GRANT;
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 3'd1;
        if (dcnt_q == 3'(DRAIN_CYC - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner;
          dcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end
  // state registers; reset aborts any grant with no drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      dcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      dcnt_q  <= dcnt_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_io_wr_arbiter.sv
// tb_io_wr_arbiter: directed self-checking bench for io_wr_arbiter (burst test selected by IO_ARB_BURST_LIMIT_EN)
module tb_io_wr_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic auto_ack, man_ack;
  int   checks = 0;
  int   errors = 0;
  io_wr_arbiter_if bus ();
  io_wr_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.io_ack_w_i = auto_ack ? bus.io_req_w_o : man_ack;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  initial begin
    reset       = 1'b1;
    auto_ack    = 1'b0;
    man_ack     = 1'b1;
    bus.req_i   = 4'b0000;
    bus.data_i  = 32'h44332211;
    next();
    next();
    settle();
    chk("rst_gnt", bus.gnt_o, 4'b0000);
    chk("rst_ack", bus.ack_o, 4'b0000);
    chk("rst_ioreq", bus.io_req_w_o, 1'b0);
    chk("rst_iodata", bus.io_data_o, 8'h00);
    next();
    reset   = 1'b0;
    next();
    settle();
    chk("idle_ack_drop", bus.ack_o, 4'b0000);
    next();
    man_ack   = 1'b0;
    bus.req_i = 4'b0110;
    settle();
    chk("gnt_latency", bus.gnt_o, 4'b0000);
    next();
    settle();
    chk("rr_first", bus.gnt_o, 4'b0010);
    chk("grant_ioreq", bus.io_req_w_o, 1'b1);
    chk("grant_iodata", bus.io_data_o, 8'h22);
    next();
    bus.req_i = 4'b0100;
    settle();
    chk("drop_ioreq", bus.io_req_w_o, 1'b0);
    next();
    settle();
    chk("drain_gnt", bus.gnt_o, 4'b0010);
    chk("drain_iodata_hold", bus.io_data_o, 8'h22);
    next();
    next();
    settle();
    chk("release_gnt", bus.gnt_o, 4'b0000);
    next();
    settle();
    chk("rr_second", bus.gnt_o, 4'b0100);
    chk("grant2_iodata", bus.io_data_o, 8'h33);
    next();
    bus.req_i = 4'b0000;
    man_ack   = 1'b1;
    settle();
    chk("drop_with_ack", bus.ack_o, 4'b0100);
    next();
    man_ack = 1'b0;
    settle();
    chk("drain1_gnt", bus.gnt_o, 4'b0100);
    chk("drain1_noack", bus.ack_o, 4'b0000);
    next();
    man_ack = 1'b1;
    settle();
    chk("drain2_gnt", bus.gnt_o, 4'b0100);
    chk("drain_ack_route", bus.ack_o, 4'b0100);
    next();
    settle();
    chk("drain_exit_gnt", bus.gnt_o, 4'b0000);
    chk("idle_ack_zero", bus.ack_o, 4'b0000);
    next();
    man_ack   = 1'b0;
    bus.req_i = 4'b1001;
    next();
    settle();
    chk("rr_wrap_gnt", bus.gnt_o, 4'b1000);
    chk("grant3_iodata", bus.io_data_o, 8'h44);
    next();
    reset   = 1'b1;
    man_ack = 1'b1;
    next();
    settle();
    chk("midrst_gnt", bus.gnt_o, 4'b0000);
    chk("midrst_ack", bus.ack_o, 4'b0000);
    chk("midrst_ioreq", bus.io_req_w_o, 1'b0);
    chk("midrst_iodata", bus.io_data_o, 8'h00);
    next();
    reset   = 1'b0;
    man_ack = 1'b0;
    next();
    settle();
    chk("post_rst_gnt", bus.gnt_o, 4'b0001);
    next();
    bus.req_i = 4'b0000;
    repeat (4) next();
    settle();
    chk("back_idle", bus.gnt_o, 4'b0000);
`ifdef IO_ARB_BURST_LIMIT_EN
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      int n_gnt = 0;
      int acks = 0;
      logic [3:0] cur = 4'b0000;
      next();
      reset = 1'b1;
      next();
      reset     = 1'b0;
      bus.req_i = 4'b1111;
      auto_ack  = 1'b1;
      for (int c = 0; c < 80 && n_gnt < 5; c++) begin
        settle();
        if (bus.gnt_o != cur) begin
          if (cur != 4'b0000) begin
            chk("burst_len", acks, 4);
            chk("burst_order", cur, 32'(1) << order[n_gnt]);
            n_gnt++;
          end
          cur  = bus.gnt_o;
          acks = 0;
        end
        if (bus.ack_o != 4'b0000) begin
          chk("burst_ack_owner", bus.ack_o, cur);
          acks++;
        end
        next();
      end
      chk("burst_grants", n_gnt, 5);
    end
`else
    begin
      int acks = 0;
      bus.req_i = 4'b0001;
      auto_ack  = 1'b1;
      next();
      for (int c = 0; c < 20; c++) begin
        settle();
        chk("nolimit_gnt", bus.gnt_o, 4'b0001);
        if (bus.ack_o == 4'b0001) acks++;
        next();
      end
      settle();
      chk("nolimit_acks", acks, 20);
      chk("nolimit_still", bus.gnt_o, 4'b0001);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
